// File: rtl/dino_pkg.sv
// Shared constants for the dino sprite path: sprite geometry, ROM index packing
// and statistics widths.
package dino_pkg;

    localparam int unsigned SPRITE_W       = 8;
    localparam int unsigned SPRITE_H       = 8;
    localparam int unsigned SPRITE_IDX_W   = 6;
    localparam int unsigned TEXEL_W        = 3;
    localparam int unsigned SCREEN_COORD_W = 10;

    localparam int unsigned           LIT_CNT_W   = 12;
    localparam logic [LIT_CNT_W-1:0] LIT_CNT_MAX = '1;

    // ROM index is row-major: {row, col}.
    function automatic logic [SPRITE_IDX_W-1:0] pack_idx(input logic [TEXEL_W-1:0] row,
                                                         input logic [TEXEL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/dino_sprite_bbox.sv
// Combinational sprite box test: pixel offset from the sprite origin, in-box flag and ROM index.
// Horizontal mirroring is built only when DINO_SPRITE_FLIP_EN is defined.
module dino_sprite_bbox
    import dino_pkg::*;
#(
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned COORD_W    = SCREEN_COORD_W
) (
    input  logic [COORD_W-1:0]      pix_x,
    input  logic [COORD_W-1:0]      pix_y,
    input  logic [COORD_W-1:0]      org_x,
    input  logic [COORD_W-1:0]      org_y,
    input  logic                    flip,
    output logic                    in_box,
    output logic [SPRITE_IDX_W-1:0] idx
);

    localparam logic [COORD_W:0] BOX_W = (COORD_W+1)'(SPRITE_W << SCALE_LOG2);
    localparam logic [COORD_W:0] BOX_H = (COORD_W+1)'(SPRITE_H << SCALE_LOG2);

    logic [COORD_W:0]  dx, dy;
    logic              in_x, in_y;
    logic [TEXEL_W-1:0] col_raw, col, row;

    // One extra bit so a pixel left of / above the origin shows up as negative.
    assign dx = {1'b0, pix_x} - {1'b0, org_x};
    assign dy = {1'b0, pix_y} - {1'b0, org_y};

    assign in_x   = !dx[COORD_W] && (dx < BOX_W);
    assign in_y   = !dy[COORD_W] && (dy < BOX_H);
    assign in_box = in_x && in_y;

    assign col_raw = dx[SCALE_LOG2 +: TEXEL_W];
    assign row     = dy[SCALE_LOG2 +: TEXEL_W];

`ifdef DINO_SPRITE_FLIP_EN
    assign col = flip ? ~col_raw : col_raw;
`else
    logic unused_flip;
    assign unused_flip = flip;
    assign col         = col_raw;
`endif

    assign idx = in_box ? pack_idx(row, col) : '0;

endmodule

// File: rtl/dino_sprite_scan.sv
// Pixel-side sprite scan: shadowed sprite position, two-stage ROM lookup pipeline and per-frame
// lit statistics. Define DINO_SPRITE_FLIP_EN to honour i_flip as a horizontal mirror.
module dino_sprite_scan
    import dino_pkg::*;
#(
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned COORD_W    = SCREEN_COORD_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COORD_W-1:0]      i_pix_x,
    input  logic [COORD_W-1:0]      i_pix_y,
    input  logic                    i_pix_valid,
    input  logic                    i_frame_start,
    input  logic [COORD_W-1:0]      i_sprite_x,
    input  logic [COORD_W-1:0]      i_sprite_y,
    input  logic                    i_flip,
    output logic [SPRITE_IDX_W-1:0] o_rom_counter,
    input  logic                    i_sprite_color,
    output logic                    o_pixel_valid,
    output logic                    o_pixel_on,
    output logic                    o_frame_lit,
    output logic [LIT_CNT_W-1:0]    o_lit_count
);

    logic [COORD_W-1:0]      shadow_x_q, shadow_y_q;
    logic                    flip_eff;
    logic                    bbox_in_box;
    logic [SPRITE_IDX_W-1:0] bbox_idx;

    logic [SPRITE_IDX_W-1:0] rom_counter_q;
    logic                    in_box_q, valid_q;
    logic                    pixel_valid_q, pixel_on_q;
    logic                    lit_now;
    logic [LIT_CNT_W-1:0]    run_q, run_d;
    logic [LIT_CNT_W-1:0]    lit_count_q;
    logic                    frame_lit_q;

`ifdef DINO_SPRITE_FLIP_EN
    logic flip_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flip_q <= 1'b0;
        end else if (i_frame_start) begin
            flip_q <= i_flip;
        end
    end

    assign flip_eff = flip_q;
`else
    logic unused_flip;
    assign unused_flip = i_flip;
    assign flip_eff    = 1'b0;
`endif

    dino_sprite_bbox #(
        .SCALE_LOG2 (SCALE_LOG2),
        .COORD_W    (COORD_W)
    ) u_bbox (
        .pix_x  (i_pix_x),
        .pix_y  (i_pix_y),
        .org_x  (shadow_x_q),
        .org_y  (shadow_y_q),
        .flip   (flip_eff),
        .in_box (bbox_in_box),
        .idx    (bbox_idx)
    );

    // A lit pixel landing on the frame-start cycle opens the new frame's count.
    always_comb begin
        lit_now = valid_q & in_box_q & i_sprite_color;
        run_d   = run_q;
        if (i_frame_start) begin
            run_d = LIT_CNT_W'(lit_now);
        end else if (lit_now && (run_q != LIT_CNT_MAX)) begin
            run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_x_q    <= '0;
            shadow_y_q    <= '0;
            rom_counter_q <= '0;
            in_box_q      <= 1'b0;
            valid_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_on_q    <= 1'b0;
            run_q         <= '0;
            lit_count_q   <= '0;
            frame_lit_q   <= 1'b0;
        end else begin
            if (i_frame_start) begin
                shadow_x_q  <= i_sprite_x;
                shadow_y_q  <= i_sprite_y;
                lit_count_q <= run_q;
                frame_lit_q <= (run_q != '0);
            end
            // Index holds through blanking so the ROM address does not toggle needlessly.
            if (i_pix_valid) begin
                rom_counter_q <= bbox_idx;
                in_box_q      <= bbox_in_box;
                valid_q       <= 1'b1;
            end else begin
                in_box_q <= 1'b0;
                valid_q  <= 1'b0;
            end
            pixel_valid_q <= valid_q;
            pixel_on_q    <= lit_now;
            run_q         <= run_d;
        end
    end

    assign o_rom_counter = rom_counter_q;
    assign o_pixel_valid = pixel_valid_q;
    assign o_pixel_on    = pixel_on_q;
    assign o_frame_lit   = frame_lit_q;
    assign o_lit_count   = lit_count_q;

endmodule

// File: tb/tb_dino_sprite_scan.sv
// Self-checking bench for dino_sprite_scan: hand vectors for the box corners and frame corner cases,
// plus randomized frames checked every cycle against an arithmetic reference model.
module tb_dino_sprite_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] i_pix_x, i_pix_y, i_sprite_x, i_sprite_y;
    logic       i_pix_valid, i_frame_start, i_flip;
    logic [5:0] o_rom_counter;
    logic       i_sprite_color;
    logic       o_pixel_valid, o_pixel_on, o_frame_lit;
    logic [11:0] o_lit_count;

    // Sprite bitmap, row r in bits [8r +: 8], bit c = column c. 27 lit texels.
    logic [63:0] rom = {8'b00000000, 8'b00000000, 8'b01111000, 8'b11111100,
                        8'b00111110, 8'b00000111, 8'b00011111, 8'b00001111};

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int m_sx, m_sy, m_rc, m_run, m_cnt;
    bit m_fl, m_pend_v, m_pend_on, m_pv_o, m_on_o, m_lit;

    always #5 clk = ~clk;

    assign i_sprite_color = rom[o_rom_counter];

    dino_sprite_scan #(
        .SCALE_LOG2 (2),
        .COORD_W    (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pix_x        (i_pix_x),
        .i_pix_y        (i_pix_y),
        .i_pix_valid    (i_pix_valid),
        .i_frame_start  (i_frame_start),
        .i_sprite_x     (i_sprite_x),
        .i_sprite_y     (i_sprite_y),
        .i_flip         (i_flip),
        .o_rom_counter  (o_rom_counter),
        .i_sprite_color (i_sprite_color),
        .o_pixel_valid  (o_pixel_valid),
        .o_pixel_on     (o_pixel_on),
        .o_frame_lit    (o_frame_lit),
        .o_lit_count    (o_lit_count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void ref_map(input int px, input int py, input int sx, input int sy,
                                    input bit fl, output bit inb, output int idx);
        int dx, dy, col, row;
        dx  = px - sx;
        dy  = py - sy;
        inb = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
        col = dx / 4;
        row = dy / 4;
`ifdef DINO_SPRITE_FLIP_EN
        if (fl) col = 7 - col;
`endif
        idx = inb ? row * 8 + col : 0;
    endfunction

    task automatic model_step(input int px, input int py, input bit pv, input bit fs,
                              input int sx, input int sy, input bit fl, input bit r);
        bit inb, lit_now;
        int idx;
        if (r) begin
            m_sx = 0; m_sy = 0; m_fl = 0; m_rc = 0; m_run = 0; m_cnt = 0;
            m_pend_v = 0; m_pend_on = 0; m_pv_o = 0; m_on_o = 0; m_lit = 0;
            return;
        end
        ref_map(px, py, m_sx, m_sy, m_fl, inb, idx);
        lit_now = m_pend_on;
        m_on_o  = m_pend_on;
        m_pv_o  = m_pend_v;
        if (pv) begin
            m_rc      = idx;
            m_pend_v  = 1;
            m_pend_on = inb && rom[idx];
        end else begin
            m_pend_v  = 0;
            m_pend_on = 0;
        end
        if (fs) begin
            m_cnt = m_run;
            m_lit = (m_run != 0);
            m_run = lit_now ? 1 : 0;
            m_sx  = sx;
            m_sy  = sy;
            m_fl  = fl;
        end else if (lit_now && m_run < 4095) begin
            m_run++;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare every output.
    task automatic tick(input int px, input int py, input bit pv, input bit fs,
                        input int sx, input int sy, input bit fl, input bit r);
        i_pix_x       = 10'(px);
        i_pix_y       = 10'(py);
        i_pix_valid   = pv;
        i_frame_start = fs;
        i_sprite_x    = 10'(sx);
        i_sprite_y    = 10'(sy);
        i_flip        = fl;
        rst           = r;
        model_step(px, py, pv, fs, sx, sy, fl, r);
        @(posedge clk);
        @(negedge clk);
        check("rom_counter", int'(o_rom_counter), m_rc);
        check("pixel_valid", int'(o_pixel_valid), int'(m_pv_o));
        check("pixel_on",    int'(o_pixel_on),    int'(m_on_o));
        check("frame_lit",   int'(o_frame_lit),   int'(m_lit));
        check("lit_count",   int'(o_lit_count),   m_cnt);
    endtask

    task automatic idle(input int n, input int sx, input int sy);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, sx, sy, 0, 0);
    endtask

    task automatic scan_window(input int sx, input int sy);
        for (int y = 190; y <= 240; y++)
            for (int x = 80; x <= 150; x++)
                tick(x, y, 1, 0, sx, sy, 0, 0);
    endtask

    typedef struct {
        int px;
        int py;
        int rc;
        bit on;
    } vec_t;

    vec_t tbl[8];
    int   exp_flip;

    initial begin
        tbl[0] = '{100, 200,  0, 1};
        tbl[1] = '{131, 231, 63, 0};
        tbl[2] = '{132, 200,  0, 0};
        tbl[3] = '{ 99, 200,  0, 0};
        tbl[4] = '{104, 204,  9, 1};
        tbl[5] = '{115, 216, 35, 1};
        tbl[6] = '{100, 232,  0, 0};
        tbl[7] = '{120, 212, 29, 1};

        @(negedge clk);
        tick(0, 0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 0, 1);
        check("reset_rom_counter", int'(o_rom_counter), 0);
        check("reset_pixel_on",    int'(o_pixel_on),    0);
        check("reset_lit_count",   int'(o_lit_count),   0);

        // Box corners and interior texels
        tick(0, 0, 0, 1, 100, 200, 0, 0);
        idle(2, 100, 200);
        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].px, tbl[i].py, 1, 0, 100, 200, 0, 0);
            check("tbl_rc", int'(o_rom_counter), tbl[i].rc);
            if (i > 0) check("tbl_on", int'(o_pixel_on), int'(tbl[i-1].on));
        end
        idle(1, 100, 200);
        check("tbl_on_last", int'(o_pixel_on), int'(tbl[7].on));
        idle(2, 100, 200);

        // Full-frame statistics, then an empty frame
        tick(0, 0, 0, 1, 100, 200, 0, 0);
        scan_window(100, 200);
        idle(2, 100, 200);
        tick(0, 0, 0, 1, 1000, 1000, 0, 0);
        check("frame_count", int'(o_lit_count), 432);
        check("frame_lit",   int'(o_frame_lit), 1);
        scan_window(1000, 1000);
        idle(2, 1000, 1000);
        tick(0, 0, 0, 1, 100, 200, 0, 0);
        check("empty_count", int'(o_lit_count), 0);
        check("empty_lit",   int'(o_frame_lit), 0);

        // Mid-frame move: position only changes at frame start, coincident pixel uses old one
        tick(104, 204, 1, 0, 300, 200, 0, 0);
        check("move_old_rc", int'(o_rom_counter), 9);
        tick(100, 200, 1, 0, 300, 200, 0, 0);
        check("move_old_on", int'(o_pixel_on), 1);
        idle(2, 300, 200);
        tick(104, 204, 1, 1, 300, 200, 0, 0);
        check("move_coinc_rc", int'(o_rom_counter), 9);
        tick(104, 204, 1, 0, 300, 200, 0, 0);
        check("move_new_rc", int'(o_rom_counter), 0);
        tick(300, 200, 1, 0, 300, 200, 0, 0);
        check("move_new_on", int'(o_pixel_on), 0);
        idle(1, 300, 200);
        check("move_new_hit", int'(o_pixel_on), 1);
        idle(2, 300, 200);

        // Flip
        tick(0, 0, 0, 1, 100, 200, 1, 0);
        tick(100, 200, 1, 0, 100, 200, 0, 0);
`ifdef DINO_SPRITE_FLIP_EN
        exp_flip = 7;
`else
        exp_flip = 0;
`endif
        check("flip_rc", int'(o_rom_counter), exp_flip);
        idle(2, 100, 200);

        // Off-screen clipping at the right edge
        tick(0, 0, 0, 1, 620, 200, 0, 0);
        tick(639, 200, 1, 0, 620, 200, 0, 0);
        check("clip_rc", int'(o_rom_counter), 4);
        tick(0, 200, 1, 0, 620, 200, 0, 0);
        check("clip_wrap_rc", int'(o_rom_counter), 0);
        tick(5, 204, 1, 0, 620, 200, 0, 0);
        check("clip_wrap_on", int'(o_pixel_on), 0);
        idle(2, 620, 200);

        // Saturating count: one lit pixel held for more than 4095 cycles
        tick(0, 0, 0, 1, 100, 200, 0, 0);
        for (int i = 0; i < 4200; i++) tick(100, 200, 1, 0, 100, 200, 0, 0);
        idle(2, 100, 200);
        tick(0, 0, 0, 1, 100, 200, 0, 0);
        check("sat_count", int'(o_lit_count), 4095);

        // Reset mid-frame
        for (int i = 0; i < 5; i++) tick(100, 200, 1, 0, 100, 200, 0, 0);
        tick(104, 204, 1, 1, 500, 500, 1, 1);
        check("rst_rc",    int'(o_rom_counter), 0);
        check("rst_pv",    int'(o_pixel_valid), 0);
        check("rst_on",    int'(o_pixel_on),    0);
        check("rst_lit",   int'(o_frame_lit),   0);
        check("rst_count", int'(o_lit_count),   0);
        tick(0, 0, 1, 0, 100, 200, 0, 0);
        tick(4, 4, 1, 0, 100, 200, 0, 0);
        check("rst_shadow_rc", int'(o_rom_counter), 9);
        tick(31, 31, 1, 0, 100, 200, 0, 0);
        idle(2, 100, 200);
        tick(0, 0, 0, 1, 100, 200, 0, 0);
        check("rst_post_count", int'(o_lit_count), 2);

        // Randomized frames against the model
        for (int f = 0; f < 8; f++) begin
            int sx, sy, px, py;
            bit fl;
            sx = $urandom_range(0, 1000);
            sy = $urandom_range(0, 1000);
            fl = 1'($urandom_range(0, 1));
            tick(0, 0, 0, 1, sx, sy, fl, 0);
            for (int i = 0; i < 700; i++) begin
                px = (sx + $urandom_range(0, 44) - 6 + 1024) % 1024;
                py = (sy + $urandom_range(0, 44) - 6 + 1024) % 1024;
                tick(px, py, ($urandom_range(0, 9) < 8), 0,
                     $urandom_range(0, 1023), $urandom_range(0, 1023),
                     1'($urandom_range(0, 1)), 0);
            end
            idle(2, sx, sy);
        end
        tick(0, 0, 0, 1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dino_sprite_scan.md
# dino_sprite_scan

Pixel-side consumer of the dino sprite ROM. It takes the VGA pixel stream and the dino's top-left position, and decides whether each pixel falls inside the scaled 8x8 sprite box. For pixels inside the box it drives the 6-bit ROM index and samples the returned colour bit. The result is a registered "sprite pixel on" stream for the pixel mixer, plus per-frame statistics for the game logic.

## Interface
- `SCALE_LOG2`, default 2: each sprite texel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels, so the box is (8<<SCALE_LOG2) pixels square.
- `COORD_W`, default 10: width of screen coordinates.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `i_pix_x` input COORD_W: current pixel column.
- `i_pix_y` input COORD_W: current pixel row.
- `i_pix_valid` input 1: active-video qualifier for `i_pix_x`/`i_pix_y`.
- `i_frame_start` input 1: one-cycle pulse at frame start, normally during vertical blank.
- `i_sprite_x` input COORD_W: requested sprite left edge.
- `i_sprite_y` input COORD_W: requested sprite top edge.
- `i_flip` input 1: horizontal mirror request; honoured only under the configuration macro.
- `o_rom_counter` output 6: ROM index {row[2:0], col[2:0]}.
- `i_sprite_color` input 1: ROM colour bit. It is combinational from `o_rom_counter`, valid in the same cycle.
- `o_pixel_valid` output 1: qualifier for `o_pixel_on`.
- `o_pixel_on` output 1: the sprite is opaque at this pixel.
- `o_frame_lit` output 1: at least one sprite pixel was lit in the previous frame.
- `o_lit_count` output 12: number of lit pixels in the previous frame, saturating.

## Operation
- **Shadow position.** `i_sprite_x`, `i_sprite_y` and `i_flip` are captured into shadow registers on the cycle `i_frame_start` is high. All box math uses the shadow copies, so a mid-frame position change never tears the sprite.
- **Stage 1** (registered on cycles with `i_pix_valid` high):
  - dx = pix_x − shadow_x and dy = pix_y − shadow_y, both computed COORD_W+1 bits wide and signed.
  - in_box when 0 ≤ dx < (8<<SCALE_LOG2) and 0 ≤ dy < (8<<SCALE_LOG2).
  - col = dx >> SCALE_LOG2 and row = dy >> SCALE_LOG2, low 3 bits of each.
  - `o_rom_counter` = {row, col} when in_box, else 0.
  - in_box_q and valid_q are registered alongside the index.
- **Stage 2** (registered): `o_pixel_valid` = valid_q; `o_pixel_on` = valid_q & in_box_q & `i_sprite_color`.
- **Partial visibility.** The sprite may sit partly off-screen: no wrap-around, and negative or oversized dx/dy are simply out of box.
- **Statistics.**
  - The running lit counter increments on each cycle where stage 2 produces `o_pixel_on` = 1, and saturates at 4095.
  - On `i_frame_start`, `o_lit_count` ← running counter and `o_frame_lit` ← (running ≠ 0). The running counter then restarts.
  - A stage-2 lit pixel in the same cycle as `i_frame_start` counts as the first pixel of the new frame; the running counter loads 1.
- **Pixel coincident with `i_frame_start`.** That pixel uses the old shadow position; the new position applies from the next cycle.
- **Invalid pixels.** While `i_pix_valid` is low, stage 1 registers in_box = 0 and valid = 0, and `o_rom_counter` holds its previous value.
- **Reset mid-frame.** Reset wins over all other inputs. The pipeline drains to zero and the shadow position, flip and running counter clear. The partial frame's statistics are discarded.

## Timing
- Reset value 0 on every output: `o_rom_counter`, `o_pixel_valid`, `o_pixel_on`, `o_frame_lit`, `o_lit_count`.
- `o_rom_counter` follows the pixel inputs by 1 cycle.
- `o_pixel_on` and `o_pixel_valid` follow by 2 cycles. Upstream delays hsync/vsync by 2 to match.
- Full throughput: one pixel per clock, with no back-pressure.
- The ROM read is combinational: `i_sprite_color` must settle within the stage-1 → stage-2 cycle.
- Shadow registers and statistics outputs update exactly 1 cycle after the `i_frame_start` edge.

## Configuration
- Macro `DINO_SPRITE_FLIP_EN`.
- Defined: when shadow flip is 1, col = 7 − (dx >> SCALE_LOG2), mirroring the dino horizontally.
- Undefined: `i_flip` is ignored and the shadow flip register is not built. The port remains so that instantiations are identical either way.

## Structure
- Shared package `dino_pkg` holds:
  - SPRITE_W = 8, SPRITE_H = 8, SPRITE_IDX_W = 6.
  - The {row, col} index packing order.
  - The screen coordinate width.
  - The lit-count width (12) and its saturation constant.
- One natural sub-module: `dino_sprite_bbox`, the combinational dx/dy, in-box and row/col calculation. The top level keeps the shadow registers, pipeline and statistics.

## Test plan
All scenarios use SCALE_LOG2 = 2 and a shadow position of (100, 200) loaded by a frame-start pulse.
- **Box corners.** Pixel (100,200) valid → `o_rom_counter` = 0 one cycle later. Pixel (131,231) → counter = 63. Pixel (132,200) → in_box 0, `o_pixel_on` = 0 two cycles later.
- **Full-frame count.** Scan a full 640x480 frame, then pulse `i_frame_start` → `o_lit_count` = 432 (27 lit texels × 16) and `o_frame_lit` = 1. After a further frame with the sprite at (1000,1000): count = 0 and `o_frame_lit` = 0.
- **Mid-frame move.** Change `i_sprite_x` to 300 mid-frame → pixel (100,200) remains in-box until the next `i_frame_start`. After it, pixel (300,200) maps to counter 0.
- **Flip.** With `DINO_SPRITE_FLIP_EN` defined and `i_flip` = 1 at frame start, pixel (100,200) → counter 7. Without the macro → counter 0.
- **Off-screen clipping.** Sprite at x = 620: pixel (639,200) → counter {0,4}, and no wrap hit at x = 0.
- **Reset mid-frame.** Assert `rst` for 1 cycle mid-frame → all outputs 0 on the next cycle, shadow position (0,0), and the next frame-start reports `o_lit_count` counting only post-reset pixels.
